opl3_bus_write_if: RTL and testbench

- Upstream neighbour of the OPL3 register file.
- Accepts raw host-bus writes from the GPIO header: 8-bit data, an address/data select line, a bank line, and a write strobe.
- Synchronises and deglitches the strobe into the clk domain, then tracks the per-bank register index latch.
- Queues completed {address, data} writes in a FIFO and presents them to the register file over a valid/ready handshake.

---
 rtl/opl3_bus_write_if.sv | 140 ++++++++++++++
 tb/tb_opl3_bus_write_if.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/opl3_bus_write_if.sv
// Host-bus write front end for the OPL3 register file: synchronises and deglitches the
// GPIO write strobe, tracks per-bank index latches and queues {addr, data} writes.
module opl3_bus_write_if #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC    = 3,
    parameter int FIFO_DEPTH  = 16,
    parameter int ADDR_WIDTH  = 9
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [7:0]                    bus_d,
    input  logic                          bus_a0,
    input  logic                          bus_bank,
    input  logic                          bus_wr,
    output logic                          wr_valid,
    output logic [ADDR_WIDTH-1:0]         wr_addr,
    output logic [7:0]                    wr_data,
    input  logic                          wr_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          ovf_clr
);
    // Handshake: an entry moves when wr_valid & wr_ready are both high at a rising clk edge;
    // wr_addr/wr_data are stable while wr_valid is high and wr_ready is low.

    localparam int         PW       = $clog2(FIFO_DEPTH);
    localparam int         EW       = ADDR_WIDTH + 8;
    localparam logic [3:0] FILT_MAX = 4'(FILT_CYC);

    logic [1:0] rst_pipe;
    logic       rst_n_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_pipe <= 2'b00;
        else          rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n_i = rst_pipe[1];

    // Strobe chain resets to 1 so a strobe held high through reset never looks like a new edge.
    logic [SYNC_STAGES-1:0] wr_sync;
    logic [9:0]             fld_sync [SYNC_STAGES];
    logic                   wr_s;
    logic [9:0]             fld;

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_sync <= '1;
            for (int i = 0; i < SYNC_STAGES; i++) fld_sync[i] <= '0;
        end else begin
            wr_sync     <= {wr_sync[SYNC_STAGES-2:0], bus_wr};
            fld_sync[0] <= {bus_bank, bus_a0, bus_d};
            for (int i = 1; i < SYNC_STAGES; i++) fld_sync[i] <= fld_sync[i-1];
        end
    end
    assign wr_s = wr_sync[SYNC_STAGES-1];
    assign fld  = fld_sync[SYNC_STAGES-1];

    logic [3:0] filt_cnt, cnt_nxt;
    logic       armed, filt, filt_d, wr_event;
    logic [9:0] cap;

    always_comb begin
        cnt_nxt = '0;
        if (wr_s && armed) cnt_nxt = (filt_cnt == FILT_MAX) ? filt_cnt : filt_cnt + 4'd1;
    end

    // Fields are captured when the count first reaches its limit, while the strobe is still high.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            armed    <= 1'b0;
            filt_cnt <= '0;
            filt     <= 1'b0;
            filt_d   <= 1'b0;
            cap      <= '0;
        end else begin
            armed    <= armed | ~wr_s;
            filt_cnt <= cnt_nxt;
            filt     <= (cnt_nxt == FILT_MAX);
            filt_d   <= filt;
            if (cnt_nxt == FILT_MAX && filt_cnt != FILT_MAX) cap <= fld;
        end
    end
    assign wr_event = filt & ~filt_d;

    logic [7:0] idx_latch [2];

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            idx_latch[0] <= '0;
            idx_latch[1] <= '0;
        end else if (wr_event && !cap[8]) begin
            idx_latch[cap[9]] <= cap[7:0];
        end
    end

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [PW:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, level_nxt;
    logic [EW-1:0] push_entry, head_nxt;
    logic          full, pop, push_req, push, drop;

    always_comb begin
        push_entry = {ADDR_WIDTH'({cap[9], idx_latch[cap[9]]}), cap[7:0]};
        full       = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
        pop        = wr_valid & wr_ready;
        push_req   = wr_event & cap[8];
        push       = push_req & (~full | pop);
        drop       = push_req & full & ~pop;
        wr_ptr_nxt = wr_ptr + (PW+1)'(push);
        rd_ptr_nxt = rd_ptr + (PW+1)'(pop);
        level_nxt  = wr_ptr_nxt - rd_ptr_nxt;
        // Bypass the array when the new head is the slot being written this cycle.
        if (push && rd_ptr_nxt[PW-1:0] == wr_ptr[PW-1:0]) head_nxt = push_entry;
        else                                               head_nxt = mem[rd_ptr_nxt[PW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= push_entry;
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            overflow <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            wr_valid <= (level_nxt != '0);
            if (level_nxt != '0) {wr_addr, wr_data} <= head_nxt;
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    assign fifo_level = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_opl3_bus_write_if.sv
// Self-checking bench for opl3_bus_write_if: directed scenarios plus randomized bus writes
// compared against a queue-based model of index latches and the write FIFO.
module tb_opl3_bus_write_if;
    localparam int SYNC_STAGES = 2;
    localparam int FILT_CYC    = 3;
    localparam int FIFO_DEPTH  = 16;
    localparam int ADDR_WIDTH  = 9;
    localparam int EW          = ADDR_WIDTH + 8;
    localparam int LW          = $clog2(FIFO_DEPTH) + 1;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic [7:0]            bus_d = '0;
    logic                  bus_a0 = 1'b0;
    logic                  bus_bank = 1'b0;
    logic                  bus_wr = 1'b0;
    logic                  wr_valid;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [7:0]            wr_data;
    logic                  wr_ready = 1'b0;
    logic [LW-1:0]         fifo_level;
    logic                  overflow;
    logic                  ovf_clr = 1'b0;

    opl3_bus_write_if #(
        .SYNC_STAGES(SYNC_STAGES), .FILT_CYC(FILT_CYC),
        .FIFO_DEPTH(FIFO_DEPTH), .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus_d(bus_d), .bus_a0(bus_a0), .bus_bank(bus_bank),
        .bus_wr(bus_wr), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .fifo_level(fifo_level), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Reference model state
    logic [EW-1:0] exp_q[$];
    logic [7:0]    m_latch [2];
    logic          exp_ovf;
    int            n_checks = 0;
    int            n_err = 0;
    int            pop_count = 0;
    bit            rand_ready = 1'b0;
    logic          hold_prev = 1'b0;
    logic [EW-1:0] hold_val = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) wr_ready = 1'($urandom_range(0, 1));
    endtask

    function automatic logic [EW-1:0] entry(input logic bank, input logic [7:0] idx,
                                            input logic [7:0] d);
        logic [EW-1:0] e;
        e = {bank, idx, d};
        return e;
    endfunction

    // Model rule: a strobe held >= FILT_CYC cycles is one write; index writes load the bank
    // latch, data writes queue {bank, latch, data} unless the queue is full with no drain.
    task automatic model_write(input logic a0, input logic bank, input logic [7:0] d,
                               input int hi);
        if (hi >= FILT_CYC) begin
            if (!a0) m_latch[bank] = d;
            else if (!wr_ready && !rand_ready && exp_q.size() >= FIFO_DEPTH) exp_ovf = 1'b1;
            else exp_q.push_back(entry(bank, m_latch[bank], d));
        end
    endtask

    task automatic bus_write(input logic a0, input logic bank, input logic [7:0] d,
                             input int hi);
        bus_a0 = a0; bus_bank = bank; bus_d = d;
        model_write(a0, bank, d, hi);
        tick();
        bus_wr = 1'b1;
        repeat (hi) tick();
        bus_wr = 1'b0;
        repeat (SYNC_STAGES + FILT_CYC + 3) tick();
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0 && fifo_level == '0 && !wr_valid) break;
            tick();
        end
        check({tag, "_drained"}, 32'(exp_q.size()), 0);
        check({tag, "_level0"}, 32'(fifo_level), 0);
    endtask

    // Scoreboard: every pop must match the queue head; a stalled head must not move.
    always @(negedge clk) begin
        if (reset_n) begin
            if (hold_prev) begin
                check("hold_valid", 32'(wr_valid), 1);
                check("hold_entry", 32'({wr_addr, wr_data}), 32'(hold_val));
            end
            if (wr_valid && wr_ready) begin
                pop_count++;
                check("pop_entry", 32'({wr_addr, wr_data}),
                      (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hDEAD_BEEF);
            end
            hold_prev = wr_valid && !wr_ready;
            hold_val  = {wr_addr, wr_data};
        end else begin
            hold_prev = 1'b0;
        end
    end

    initial begin
        int lat;
        int pc;
        m_latch[0] = '0; m_latch[1] = '0; exp_ovf = 1'b0;

        repeat (3) tick();
        reset_n = 1'b1;
        repeat (4) tick();
        check("rst_valid", 32'(wr_valid), 0);
        check("rst_addr", 32'(wr_addr), 0);
        check("rst_data", 32'(wr_data), 0);
        check("rst_level", 32'(fifo_level), 0);
        check("rst_ovf", 32'(overflow), 0);

        // Single write latency and one-pulse output
        wr_ready = 1'b1;
        bus_write(1'b0, 1'b0, 8'h20, FILT_CYC);
        pc = pop_count;
        bus_a0 = 1'b1; bus_bank = 1'b0; bus_d = 8'h01;
        model_write(1'b1, 1'b0, 8'h01, FILT_CYC + 4);
        tick();
        bus_wr = 1'b1;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            lat++;
            if (wr_valid) break;
        end
        check("latency_in_range",
              32'(lat >= SYNC_STAGES + FILT_CYC && lat <= SYNC_STAGES + FILT_CYC + 2), 1);
        repeat (4) tick();
        bus_wr = 1'b0;
        repeat (8) tick();
        check("single_pop_count", 32'(pop_count - pc), 1);

        // Independent per-bank latches
        bus_write(1'b0, 1'b1, 8'h05, FILT_CYC);
        bus_write(1'b0, 1'b0, 8'hB0, FILT_CYC + 1);
        bus_write(1'b1, 1'b1, 8'h3C, FILT_CYC);
        bus_write(1'b1, 1'b0, 8'h11, FILT_CYC + 2);
        wait_drain("banks");

        // Glitches shorter than the filter are ignored
        pc = pop_count;
        bus_write(1'b1, 1'b0, 8'hAA, FILT_CYC - 1);
        bus_write(1'b0, 1'b0, 8'hEE, FILT_CYC - 1);
        check("glitch_level", 32'(fifo_level), 0);
        check("glitch_pops", 32'(pop_count - pc), 0);
        bus_write(1'b1, 1'b0, 8'h5A, FILT_CYC);
        wait_drain("glitch");

        // Overflow: 17 writes into a stalled 16-deep queue
        wr_ready = 1'b0;
        bus_write(1'b0, 1'b0, 8'h40, FILT_CYC);
        for (int i = 0; i <= 16; i++) bus_write(1'b1, 1'b0, 8'(i), FILT_CYC);
        check("ovf_level", 32'(fifo_level), FIFO_DEPTH);
        check("ovf_set", 32'(overflow), 32'(exp_ovf));
        wr_ready = 1'b1;
        wait_drain("ovf");
        check("ovf_sticky", 32'(overflow), 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        exp_ovf = 1'b0;
        tick();
        check("ovf_cleared", 32'(overflow), 32'(exp_ovf));

        // Full queue: push coincides with a single pop
        wr_ready = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) bus_write(1'b1, 1'b0, 8'(8'h80 + i), FILT_CYC);
        check("full_level", 32'(fifo_level), FIFO_DEPTH);
        bus_a0 = 1'b1; bus_bank = 1'b0; bus_d = 8'h90;
        exp_q.push_back(entry(1'b0, m_latch[0], 8'h90));
        tick();
        bus_wr = 1'b1;
        repeat (SYNC_STAGES + FILT_CYC) tick();
        wr_ready = 1'b1;
        tick();
        wr_ready = 1'b0;
        bus_wr = 1'b0;
        repeat (8) tick();
        check("pushpop_level", 32'(fifo_level), FIFO_DEPTH);
        check("pushpop_ovf", 32'(overflow), 0);
        wr_ready = 1'b1;
        wait_drain("pushpop");

        // Randomized writes with a randomly stalling consumer
        rand_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            int hi;
            hi = ($urandom_range(0, 3) == 0) ? $urandom_range(1, FILT_CYC - 1)
                                              : $urandom_range(FILT_CYC, FILT_CYC + 3);
            bus_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      8'($urandom_range(0, 255)), hi);
        end
        rand_ready = 1'b0;
        wr_ready = 1'b1;
        wait_drain("random");
        check("random_ovf", 32'(overflow), 0);

        // Reset with queued entries and the strobe held high across release
        wr_ready = 1'b0;
        bus_write(1'b0, 1'b1, 8'h66, FILT_CYC);
        for (int i = 0; i < 5; i++) bus_write(1'b1, 1'b1, 8'(8'h50 + i), FILT_CYC);
        check("pre_rst_level", 32'(fifo_level), 5);
        bus_a0 = 1'b1; bus_bank = 1'b1; bus_d = 8'h99;
        bus_wr = 1'b1;
        tick();
        reset_n = 1'b0;
        repeat (3) tick();
        check("in_rst_valid", 32'(wr_valid), 0);
        reset_n = 1'b1;
        exp_q.delete();
        m_latch[0] = '0; m_latch[1] = '0;
        pc = pop_count;
        repeat (15) tick();
        check("post_rst_valid", 32'(wr_valid), 0);
        check("post_rst_level", 32'(fifo_level), 0);
        bus_wr = 1'b0;
        repeat (8) tick();
        check("post_rst_fall_level", 32'(fifo_level), 0);
        wr_ready = 1'b1;
        bus_write(1'b1, 1'b1, 8'h77, FILT_CYC + 1);
        wait_drain("post_rst");
        check("post_rst_pops", 32'(pop_count - pc), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
